// File: rtl/fetch_queue.sv
// Prefetching fetch unit: req/ack memory port -> DEPTH-entry FIFO -> ID registers, with empty-FIFO bypass.
// Optional misaligned-branch trap enabled by defining FETCH_MISALIGN_EN.
module fetch_queue #(
   parameter int          DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clk_ce,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_req,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_data,
   input  logic        i_hz_data,
   input  logic        i_br_en,
   input  logic [31:0] i_br_addr,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_ret,
   output logic [31:0] o_id_ir,
   output logic        o_hz_br,
   output logic        o_misalign
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   fifo_pc   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic          id_valid;
   logic [31:0]   id_pc;
   logic [31:0]   id_ret;
   logic [31:0]   id_ir;
   logic          misalign_q;
   logic [31:0]   br_target;

   logic full;
   logic accept;
   logic ld;
   logic pop;
   logic bypass;
   logic push;

   assign br_target = {i_br_addr[31:2], 2'b00};

`ifndef FETCH_MISALIGN_EN
   logic unused_br_lsbs;
   assign unused_br_lsbs = ^i_br_addr[1:0];
   assign misalign_q     = 1'b0;
`endif

   // The accepted word goes to ID directly only when ID is loading and the FIFO has nothing older.
   always_comb begin
      full      = (count == CW'(DEPTH));
      o_mem_req = !full && !misalign_q && !i_rst;
      accept    = i_mem_ack && o_mem_req && i_clk_ce && !i_br_en;
      ld        = i_clk_ce && (!id_valid || !i_hz_data);
      pop       = ld && !i_br_en && (count != '0);
      bypass    = ld && !i_br_en && (count == '0) && accept;
      push      = accept && !bypass;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc   <= RESET_VECTOR;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
`ifdef FETCH_MISALIGN_EN
         misalign_q <= 1'b0;
`endif
      end else if (i_clk_ce) begin
         if (i_br_en) begin
            fetch_pc   <= br_target;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
`ifdef FETCH_MISALIGN_EN
            misalign_q <= |i_br_addr[1:0];
`endif
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (push)   wr_ptr   <= wr_ptr + PW'(1);
            if (pop)    rd_ptr   <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Entry storage needs no reset; count/pointers define which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= fetch_pc;
         fifo_data[wr_ptr] <= i_mem_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_ret   <= '0;
         id_ir    <= '0;
      end else if (i_clk_ce) begin
         if (i_br_en) begin
            id_valid <= 1'b0;
            id_ir    <= '0;
         end else if (ld) begin
            if (pop) begin
               id_valid <= 1'b1;
               id_pc    <= fifo_pc[rd_ptr];
               id_ret   <= fifo_pc[rd_ptr] + 32'd4;
               id_ir    <= fifo_data[rd_ptr];
            end else if (bypass) begin
               id_valid <= 1'b1;
               id_pc    <= fetch_pc;
               id_ret   <= fetch_pc + 32'd4;
               id_ir    <= i_mem_data;
            end else begin
               id_valid <= 1'b0;
               id_ir    <= '0;
            end
         end
      end
   end

   assign o_mem_addr = fetch_pc;
   assign o_id_pc    = id_pc;
   assign o_id_ret   = id_ret;
   assign o_id_ir    = id_ir;
   assign o_hz_br    = !id_valid;
   assign o_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); covers streaming, hazard stall,
// branch flush, sparse acks, clock-enable freeze, branch alignment and mid-request reset.
module tb_fetch_queue;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_clk_ce;
   logic [31:0] o_mem_addr;
   logic        o_mem_req;
   logic        i_mem_ack;
   logic [31:0] i_mem_data;
   logic        i_hz_data;
   logic        i_br_en;
   logic [31:0] i_br_addr;
   logic [31:0] o_id_pc;
   logic [31:0] o_id_ret;
   logic [31:0] o_id_ir;
   logic        o_hz_br;
   logic        o_misalign;

   int checks = 0;
   int errors = 0;

   fetch_queue #(.DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clk_ce   (i_clk_ce),
      .o_mem_addr (o_mem_addr),
      .o_mem_req  (o_mem_req),
      .i_mem_ack  (i_mem_ack),
      .i_mem_data (i_mem_data),
      .i_hz_data  (i_hz_data),
      .i_br_en    (i_br_en),
      .i_br_addr  (i_br_addr),
      .o_id_pc    (o_id_pc),
      .o_id_ret   (o_id_ret),
      .o_id_ir    (o_id_ir),
      .o_hz_br    (o_hz_br),
      .o_misalign (o_misalign)
   );

   always #5 i_clk = ~i_clk;

   // Memory returns a word tagged with its own address so ordering errors are visible.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'hDEAD_0000;
   endfunction

   assign i_mem_data = mem_word(o_mem_addr);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic ce, input logic ack, input logic hz,
                                input logic br, input logic [31:0] br_addr);
      i_clk_ce  = ce;
      i_mem_ack = ack;
      i_hz_data = hz;
      i_br_en   = br;
      i_br_addr = br_addr;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst     = 1'b1;
      i_clk_ce  = 1'b1;
      i_mem_ack = 1'b0;
      i_hz_data = 1'b0;
      i_br_en   = 1'b0;
      i_br_addr = '0;
      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("rst_req",      32'(o_mem_req),  32'd0);
      checkOutput("rst_addr",     o_mem_addr,      32'h0);
      checkOutput("rst_hz_br",    32'(o_hz_br),    32'd1);
      checkOutput("rst_id_pc",    o_id_pc,         32'h0);
      checkOutput("rst_id_ret",   o_id_ret,        32'h0);
      checkOutput("rst_id_ir",    o_id_ir,         32'h0);
      checkOutput("rst_misalign", 32'(o_misalign), 32'd0);

      i_rst = 1'b0;
      #1;
      checkOutput("rel_req", 32'(o_mem_req), 32'd1);

      $display("[TB] streaming after reset");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s1_addr",   o_mem_addr,   32'h4);
      checkOutput("s1_id_pc",  o_id_pc,      32'h0);
      checkOutput("s1_id_ret", o_id_ret,     32'h4);
      checkOutput("s1_id_ir",  o_id_ir,      mem_word(32'h0));
      checkOutput("s1_hz_br",  32'(o_hz_br), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s2_addr",  o_mem_addr, 32'h8);
      checkOutput("s2_id_pc", o_id_pc,    32'h4);

      $display("[TB] data hazard for 10 cycles");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         checkOutput("hz_hold_pc", o_id_pc, 32'h4);
      end
      checkOutput("hz_full_req",  32'(o_mem_req), 32'd0);
      checkOutput("hz_full_addr", o_mem_addr,     32'h18);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         checkOutput("drain_pc",    o_id_pc,      32'h8 + 32'(4 * i));
         checkOutput("drain_ir",    o_id_ir,      mem_word(32'h8 + 32'(4 * i)));
         checkOutput("drain_hz_br", 32'(o_hz_br), 32'd0);
      end
      checkOutput("drain_addr", o_mem_addr, 32'h28);

      $display("[TB] branch with ack, FIFO holding 3");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
      checkOutput("br_id_ir", o_id_ir,        32'h0);
      checkOutput("br_hz_br", 32'(o_hz_br),   32'd1);
      checkOutput("br_addr",  o_mem_addr,     32'h100);
      checkOutput("br_req",   32'(o_mem_req), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("br_tgt_pc",  o_id_pc,    32'h100);
      checkOutput("br_tgt_ret", o_id_ret,   32'h104);
      checkOutput("br_tgt_ir",  o_id_ir,    mem_word(32'h100));
      checkOutput("br_nxt",     o_mem_addr, 32'h104);

      $display("[TB] ack every third cycle");
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, (k % 3) == 2, 1'b0, 1'b0, 32'h0);
         checkOutput("sp_hz_br", 32'(o_hz_br), 32'((k % 3) != 2));
         checkOutput("sp_addr",  o_mem_addr,   32'h104 + 32'(4 * ((k + 1) / 3)));
         if ((k % 3) == 2)
            checkOutput("sp_id_pc", o_id_pc, 32'h104 + 32'(4 * (k / 3)));
      end

      $display("[TB] clock enable low with ack held");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         checkOutput("ce_addr",  o_mem_addr,   32'h10C);
         checkOutput("ce_id_pc", o_id_pc,      32'h108);
         checkOutput("ce_hz_br", 32'(o_hz_br), 32'd0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("ce_resume_pc",   o_id_pc,    32'h10C);
      checkOutput("ce_resume_addr", o_mem_addr, 32'h110);

      $display("[TB] branch to unaligned target");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
      checkOutput("mis_addr",  o_mem_addr,   32'h100);
      checkOutput("mis_hz_br", 32'(o_hz_br), 32'd1);
`ifdef FETCH_MISALIGN_EN
      checkOutput("mis_flag", 32'(o_misalign), 32'd1);
      checkOutput("mis_req",  32'(o_mem_req),  32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("mis_stall_addr", o_mem_addr,   32'h100);
      checkOutput("mis_stall_hz",   32'(o_hz_br), 32'd1);
`else
      checkOutput("mis_flag", 32'(o_misalign), 32'd0);
      checkOutput("mis_req",  32'(o_mem_req),  32'd1);
`endif
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
      checkOutput("al_flag", 32'(o_misalign), 32'd0);
      checkOutput("al_addr", o_mem_addr,      32'h200);
      checkOutput("al_req",  32'(o_mem_req),  32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("al_id_pc",  o_id_pc,    32'h200);
      checkOutput("al_id_ret", o_id_ret,   32'h204);
      checkOutput("al_id_ir",  o_id_ir,    mem_word(32'h200));
      checkOutput("al_nxt",    o_mem_addr, 32'h204);

      $display("[TB] reset during a request");
      i_mem_ack = 1'b0;
      i_rst     = 1'b1;
      #1;
      checkOutput("mid_rst_req",   32'(o_mem_req), 32'd0);
      checkOutput("mid_rst_addr",  o_mem_addr,     32'h0);
      checkOutput("mid_rst_hz_br", 32'(o_hz_br),   32'd1);
      checkOutput("mid_rst_ir",    o_id_ir,        32'h0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
